// File: rtl/axi4_to_axi3_rd_splitter.sv
// Splits one AXI4 INCR read burst (<=256 beats) into AXI3 sub-bursts of <=16 beats and returns the data as one upstream burst.
// AR path is registered (first sub-burst one cycle after accept); R path is a zero-latency pass-through that honours s_axi_rready.
module axi4_to_axi3_rd_splitter #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 64,
  parameter int id_width_p   = 6
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [addr_width_p-1:0] s_axi_araddr,
  input  logic [id_width_p-1:0]   s_axi_arid,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [data_width_p-1:0] s_axi_rdata,
  output logic [id_width_p-1:0]   s_axi_rid,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [addr_width_p-1:0] m_axi_araddr,
  output logic [id_width_p-1:0]   m_axi_arid,
  output logic [3:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic [1:0]              m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [data_width_p-1:0] m_axi_rdata,
  input  logic [id_width_p-1:0]   m_axi_rid,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam logic [2:0] max_size_lp = 3'($clog2(data_width_p/8));

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [addr_width_p-1:0] addr_q, addr_d;
  logic [id_width_p-1:0]   id_q, id_d;
  logic [2:0]              size_q, size_d;
  logic [3:0]              cache_q, cache_d;
  logic [2:0]              prot_q, prot_d;
  logic [8:0]              ar_left_q, ar_left_d;
  logic [8:0]              r_left_q, r_left_d;
  logic                    arready_q, arready_d;
  logic                    arvalid_q, arvalid_d;

  logic [4:0] sub_beats;
  logic       ar_acc, ar_hs, r_active, r_hs;
  logic       unused_rlast;

  // Downstream rlast is redundant: upstream rlast comes from the total beat count.
  assign unused_rlast = m_axi_rlast;

  assign sub_beats = (ar_left_q > 9'd16) ? 5'd16 : ar_left_q[4:0];
  assign ar_acc    = arready_q & s_axi_arvalid;
  assign ar_hs     = arvalid_q & m_axi_arready;
  assign r_active  = (state_q != IDLE);
  assign r_hs      = r_active & m_axi_rvalid & s_axi_rready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    id_d      = id_q;
    size_d    = size_q;
    cache_d   = cache_q;
    prot_d    = prot_q;
    ar_left_d = ar_left_q;
    r_left_d  = r_left_q;
    case (state_q)
      IDLE: begin
        if (ar_acc) begin
          addr_d    = s_axi_araddr;
          id_d      = s_axi_arid;
          size_d    = s_axi_arsize;
          cache_d   = s_axi_arcache;
          prot_d    = s_axi_arprot;
          ar_left_d = {1'b0, s_axi_arlen} + 9'd1;
          r_left_d  = {1'b0, s_axi_arlen} + 9'd1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (ar_hs) begin
          ar_left_d = ar_left_q - {4'd0, sub_beats};
          // Later sub-bursts start on a size-aligned address even if the first was unaligned.
          addr_d    = (addr_q & ({addr_width_p{1'b1}} << size_q))
                    + (addr_width_p'(sub_beats) << size_q);
          if (ar_left_d == 9'd0) state_d = DRAIN;
        end
        if (r_hs) begin
          r_left_d = r_left_q - 9'd1;
          if (r_left_q == 9'd1) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (r_hs) begin
          r_left_d = r_left_q - 9'd1;
          if (r_left_q == 9'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    arready_d = (state_d == IDLE);
    arvalid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      id_q      <= '0;
      size_q    <= '0;
      cache_q   <= '0;
      prot_q    <= '0;
      ar_left_q <= '0;
      r_left_q  <= '0;
      arready_q <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      size_q    <= size_d;
      cache_q   <= cache_d;
      prot_q    <= prot_d;
      ar_left_q <= ar_left_d;
      r_left_q  <= r_left_d;
      arready_q <= arready_d;
      arvalid_q <= arvalid_d;
    end
  end

  assign s_axi_arready = arready_q;

  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arid    = id_q;
  assign m_axi_arlen   = 4'(sub_beats - 5'd1);
  assign m_axi_arsize  = size_q;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 2'b00;
  assign m_axi_arcache = cache_q;
  assign m_axi_arprot  = prot_q;
  assign m_axi_arqos   = 4'h0;

  assign s_axi_rvalid  = r_active & m_axi_rvalid;
  assign m_axi_rready  = r_active & s_axi_rready;
  assign s_axi_rdata   = m_axi_rdata;
  assign s_axi_rid     = m_axi_rid;
  assign s_axi_rresp   = m_axi_rresp;
  assign s_axi_rlast   = r_active & (r_left_q == 9'd1);

  // Hardware treats a bad burst type as INCR; only simulation flags it.
  assert property (@(posedge clk_i) disable iff (reset_i)
    (s_axi_arvalid && arready_q) |-> (s_axi_arburst == 2'b01 && s_axi_arsize <= max_size_lp));

endmodule

// File: tb/tb_axi4_to_axi3_rd_splitter.sv
// Randomized bench for axi4_to_axi3_rd_splitter against a queue-based burst/beat model.
module tb_axi4_to_axi3_rd_splitter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic [31:0] s_axi_araddr;
  logic [5:0]  s_axi_arid;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic [3:0]  s_axi_arcache;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid, s_axi_arready;
  logic [63:0] s_axi_rdata;
  logic [5:0]  s_axi_rid;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [31:0] m_axi_araddr;
  logic [5:0]  m_axi_arid;
  logic [3:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst, m_axi_arlock;
  logic [3:0]  m_axi_arcache, m_axi_arqos;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [5:0]  m_axi_rid;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi4_to_axi3_rd_splitter dut (
    .clk_i(clk), .reset_i(reset_i),
    .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arcache(s_axi_arcache),
    .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Drives one upstream burst, plays a downstream memory, and scores both sides.
  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] sz,
                           input logic [5:0] id, input bit stall, input int err_beat,
                           input int reset_at);
    logic [31:0] exp_addr[$];
    logic [3:0]  exp_len[$];
    logic [63:0] exp_dat[$];
    logic [1:0]  exp_resp[$];
    logic [31:0] a;
    logic [3:0]  cache;
    logic [2:0]  prot;
    int rem, sub, n_exp_ar;
    int pend = 0, presented = 0, beats = 0, cyc = 0, acc_cyc = -100, last_ar = -100, n_ar = 0;
    bit done = 0, up_hs, dn_ar_hs, r_hs, fin;

    a   = addr;
    rem = int'(len) + 1;
    while (rem > 0) begin
      sub = (rem > 16) ? 16 : rem;
      exp_addr.push_back(a);
      exp_len.push_back(4'(sub - 1));
      a   = ((a >> sz) << sz) + (32'(sub) << sz);
      rem = rem - sub;
    end
    n_exp_ar = exp_addr.size();

    cache = 4'($urandom);
    prot  = 3'($urandom);
    s_axi_araddr  = addr;
    s_axi_arid    = id;
    s_axi_arlen   = len;
    s_axi_arsize  = sz;
    s_axi_arburst = 2'b01;
    s_axi_arcache = cache;
    s_axi_arprot  = prot;
    s_axi_arvalid = 1'b1;
    m_axi_arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    s_axi_rready  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;

    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      up_hs    = s_axi_arvalid && s_axi_arready;
      dn_ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs     = s_axi_rvalid && s_axi_rready;
      fin      = 1'b0;
      if (up_hs) acc_cyc = cyc;
      if (m_axi_rvalid) check("rvalid_pass", s_axi_rvalid, 1'b1);
      if (s_axi_rvalid) check("rready_pass", m_axi_rready, s_axi_rready);
      if (dn_ar_hs) begin
        check("ar_not_extra", n_ar < n_exp_ar, 1'b1);
        if (exp_addr.size() > 0) begin
          check("m_araddr", m_axi_araddr, exp_addr[0]);
          check("m_arlen", m_axi_arlen, exp_len[0]);
          check("m_arid", m_axi_arid, id);
          check("m_arsize", m_axi_arsize, sz);
          check("m_arburst", m_axi_arburst, 2'b01);
          check("m_arlock", m_axi_arlock, 2'b00);
          check("m_arqos", m_axi_arqos, 4'h0);
          check("m_arcache", m_axi_arcache, cache);
          check("m_arprot", m_axi_arprot, prot);
          pend = pend + int'(exp_len[0]) + 1;
          void'(exp_addr.pop_front());
          void'(exp_len.pop_front());
        end
        if (!stall) check("ar_gap", cyc - ((n_ar == 0) ? acc_cyc : last_ar), 1);
        last_ar = cyc;
        n_ar++;
      end
      if (r_hs) begin
        beats++;
        check("beat_in_range", beats <= int'(len) + 1, 1'b1);
        if (exp_dat.size() > 0) begin
          check("rdata", s_axi_rdata, exp_dat[0]);
          check("rid", s_axi_rid, id);
          check("rresp", s_axi_rresp, exp_resp[0]);
          check("rlast", s_axi_rlast, beats == int'(len) + 1);
          void'(exp_dat.pop_front());
          void'(exp_resp.pop_front());
        end
        if (beats == int'(len) + 1) begin
          fin = 1'b1;
          check("arready_in_last_cycle", s_axi_arready, 1'b0);
        end
      end

      @(posedge clk);
      #1;
      if (up_hs) s_axi_arvalid = 1'b0;
      if (r_hs) m_axi_rvalid = 1'b0;
      if (fin) done = 1'b1;
      m_axi_arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axi_rready  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!m_axi_rvalid && pend > 0 && (!stall || $urandom_range(0, 2) != 0)) begin
        presented++;
        m_axi_rdata  = {$urandom, $urandom};
        m_axi_rid    = id;
        m_axi_rresp  = (presented == err_beat) ? 2'b10 : 2'b00;
        m_axi_rlast  = 1'($urandom);
        m_axi_rvalid = 1'b1;
        exp_dat.push_back(m_axi_rdata);
        exp_resp.push_back(m_axi_rresp);
        pend--;
      end
      if (reset_at > 0 && beats == reset_at - 1 && m_axi_rvalid) begin
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("rst_s_rvalid", s_axi_rvalid, 1'b0);
        check("rst_m_rready", m_axi_rready, 1'b0);
        check("rst_m_arvalid", m_axi_arvalid, 1'b0);
        @(posedge clk);
        #1;
        m_axi_rvalid = 1'b0;
        @(negedge clk);
        check("rst_idle_arready", s_axi_arready, 1'b1);
        @(posedge clk);
        #1;
        return;
      end
    end

    check("burst_done", done, 1'b1);
    check("ar_count", n_ar, n_exp_ar);
    @(negedge clk);
    check("arready_back", s_axi_arready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    reset_i       = 1'b1;
    s_axi_araddr  = '0;
    s_axi_arid    = '0;
    s_axi_arlen   = '0;
    s_axi_arsize  = '0;
    s_axi_arburst = 2'b01;
    s_axi_arcache = '0;
    s_axi_arprot  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rid     = '0;
    m_axi_rresp   = '0;
    m_axi_rlast   = 1'b0;
    m_axi_rvalid  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_arready", s_axi_arready, 1'b0);
    check("reset_m_arvalid", m_axi_arvalid, 1'b0);
    check("reset_s_rvalid", s_axi_rvalid, 1'b0);
    check("reset_m_rready", m_axi_rready, 1'b0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_reset_arready", s_axi_arready, 1'b1);
    @(posedge clk);
    #1;

    run_burst(32'h0000_1000, 8'd0,   3'd3, 6'h05, 1'b0, 0, 0);
    run_burst(32'h0000_3000, 8'd15,  3'd3, 6'h11, 1'b0, 0, 0);
    run_burst(32'h8000_0000, 8'd255, 3'd3, 6'h2a, 1'b0, 0, 0);
    run_burst(32'h0000_2004, 8'd39,  3'd3, 6'h3f, 1'b0, 0, 0);
    run_burst(32'h0000_4000, 8'd47,  3'd3, 6'h19, 1'b1, 7, 0);
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      run_burst(ra, 8'($urandom_range(0, 90)), 3'($urandom_range(0, 3)), 6'($urandom),
                1'b1, int'($urandom_range(1, 20)), 0);
    end
    run_burst(32'h0001_0000, 8'd63, 3'd3, 6'h0c, 1'b0, 0, 10);
    run_burst(32'h0002_0000, 8'd3,  3'd3, 6'h21, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi4_to_axi3_rd_splitter.md
# axi4_to_axi3_rd_splitter

Read-channel adapter between the accelerator/host-side AXI4 memory master and the AXI3 m00 HP port of the Zynq shell. Accepts one AXI4 INCR read burst of up to 256 beats, reissues it as a sequence of AXI3 sub-bursts of at most 16 beats each, and returns the read data upstream as a single burst with a correct `rlast`. Write channels bypass this block.

## Interface
- `addr_width_p`, 32: AR address width.
- `data_width_p`, 64: R data width.
- `id_width_p`, 6: AR/R ID width.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `reset_i`  in  1  synchronous reset, active-high.
- `s_axi_araddr`  in  `addr_width_p`  upstream burst start address.
- `s_axi_arid`  in  `id_width_p`  upstream ID.
- `s_axi_arlen`  in  8  beats-1 (0..255).
- `s_axi_arsize`  in  3  log2 bytes per beat.
- `s_axi_arburst`  in  2  must be INCR (2'b01).
- `s_axi_arcache`  in  4, `s_axi_arprot`  in  3: forwarded unchanged.
- `s_axi_arvalid`  in  1 / `s_axi_arready`  out  1.
- `s_axi_rdata`  out  `data_width_p`, `s_axi_rid`  out  `id_width_p`, `s_axi_rresp`  out  2, `s_axi_rlast`  out  1.
- `s_axi_rvalid`  out  1 / `s_axi_rready`  in  1.
- `m_axi_araddr`  out  `addr_width_p`, `m_axi_arid`  out  `id_width_p`, `m_axi_arlen`  out  4, `m_axi_arsize`  out  3, `m_axi_arburst`  out  2, `m_axi_arlock`  out  2, `m_axi_arcache`  out  4, `m_axi_arprot`  out  3, `m_axi_arqos`  out  4.
- `m_axi_arvalid`  out  1 / `m_axi_arready`  in  1.
- `m_axi_rdata`  in  `data_width_p`, `m_axi_rid`  in  `id_width_p`, `m_axi_rresp`  in  2, `m_axi_rlast`  in  1 (ignored).
- `m_axi_rvalid`  in  1 / `m_axi_rready`  out  1.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: `s_axi_arready`=1. On `s_axi_arvalid` handshake, register addr, id, size, cache, prot; `ar_left` = arlen+1 (9 bits); `r_left` = arlen+1 (9 bits); go ISSUE.
- ISSUE: `m_axi_arvalid`=1. `m_axi_arlen` = min(`ar_left`,16)-1. On `m_axi_arready`: `ar_left` -= arlen_sub+1; address = (addr with low `arsize` bits cleared) + ((arlen_sub+1) << arsize); if `ar_left` becomes 0 go DRAIN, else stay ISSUE.
- DRAIN: no AR issued; waits for remaining beats.
- R path (ISSUE and DRAIN, combinational pass-through): `s_axi_rvalid`=`m_axi_rvalid`, `m_axi_rready`=`s_axi_rready`; rdata, rid, rresp passed unchanged per beat. `s_axi_rlast` = (`r_left`==1). Each R handshake decrements `r_left`; handshake with `r_left`==1 returns to IDLE from either ISSUE or DRAIN.
- In IDLE: `m_axi_rready`=0, `s_axi_rvalid`=0.
- Constant outputs: `m_axi_arburst`=2'b01, `m_axi_arlock`=2'b00, `m_axi_arqos`=4'h0; `m_axi_arid` = registered upstream ID for every sub-burst; arsize/cache/prot registered copies.
- One upstream burst outstanding at a time; in-order return from the single downstream ID is relied on.
- Non-INCR `s_axi_arburst`, or arsize above log2(`data_width_p`/8), is an error: simulation assertion fires at accept; hardware behaviour treats it as INCR.
- Bursts do not cross 4 KB (AXI4 guarantee); splitter performs no boundary checking.

## Timing
- Reset values: `s_axi_arready`=0 during reset, 1 first cycle after; `m_axi_arvalid`=0; `s_axi_rvalid`=0; `m_axi_rready`=0; counters and registered fields 0; state IDLE.
- AR accepted at cycle t → first `m_axi_arvalid` at t+1 (registered). With `m_axi_arready` held high, N sub-bursts issue in cycles t+1..t+N.
- R data path: zero added latency, zero bubbles.
- `m_axi_arvalid` and all m_ar fields stable until handshake.
- Beats may arrive during ISSUE; simultaneous AR handshake and R handshake update both counters in the same cycle.
- Final R handshake at cycle u → `s_axi_arready`=1 at u+1; no new AR is accepted in cycle u.
- `reset_i` mid-burst: state returns to IDLE next edge, all counters cleared; downstream must be reset in the same cycle.

## Test plan
- arlen=0, addr 0x1000, size 3 → one m AR len 0 addr 0x1000; one R beat with `s_axi_rlast`=1; arready back one cycle later.
- arlen=15 → one m AR len 15; rlast only on beat 16.
- arlen=255, addr 0x8000_0000, size 3, m_arready always 1 → 16 m ARs len 15 at 0x8000_0000 + k*0x80 in consecutive cycles; 256 beats, rlast only on beat 256.
- arlen=39, addr 0x2004 (unaligned), size 3 → ARs len 15/15/7 at 0x2004, 0x2080, 0x2100; rlast on beat 40.
- Random `m_axi_arready`/`m_axi_rvalid`/`s_axi_rready` stall, beats returned during ISSUE → data/rid/rresp order preserved, SLVERR on beat 7 passed through on beat 7 only, no lost or duplicate beats.
- `reset_i` pulsed during beat 10 of a 64-beat burst → next cycle state IDLE, all valids 0; new arlen=3 burst then completes with rlast on beat 4.
